// File: rtl/demux1_2_stream.sv
// 1-to-2 stream demultiplexer with an independent DEPTH-entry FIFO per output.
// Optional pop counters (pop_cnt_0/1) are enabled by defining DEMUX_COUNT_EN.
module demux1_2_stream #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out_0,
  output logic             out_valid_0,
  input  logic             out_ready_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic             out_valid_1,
  input  logic             out_ready_1
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      pop_cnt_0,
  output logic [15:0]      pop_cnt_1
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [CW-1:0]    count  [2];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW-1:0]    rd_ptr [2];
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       out_ready;

  assign out_ready = {out_ready_1, out_ready_0};

  // Acceptance depends only on sel and registered counts; a full FIFO never
  // accepts, even when it is being popped in the same cycle.
  always_comb begin
    full     = '0;
    pop      = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      full[k] = (count[k] == CW'(DEPTH));
      pop[k]  = (count[k] != '0) && out_ready[k];
    end
    in_ready = !full[sel];
    push     = '0;
    push[0]  = in_valid && in_ready && !sel;
    push[1]  = in_valid && in_ready && sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < 2; k++) begin
        count[k]  <= '0;
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem[k][j] <= '0;
        end
      end
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= data_in;
          wr_ptr[k]         <= wr_ptr[k] + 1'b1;
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + 1'b1;
        end
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 1'b1;
          2'b01:   count[k] <= count[k] - 1'b1;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  assign data_out_0  = mem[0][rd_ptr[0]];
  assign data_out_1  = mem[1][rd_ptr[1]];
  assign out_valid_0 = (count[0] != '0);
  assign out_valid_1 = (count[1] != '0);

`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt_0 <= '0;
      pop_cnt_1 <= '0;
    end else begin
      if (pop[0]) pop_cnt_0 <= pop_cnt_0 + 16'd1;
      if (pop[1]) pop_cnt_1 <= pop_cnt_1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1_2_stream.sv
// Bench for demux1_2_stream: queue-based model checked every cycle plus
// directed vectors with literal expectations.
module tb_demux1_2_stream;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] data_out_0, data_out_1;
  logic             out_valid_0, out_valid_1;
  logic             out_ready_0 = 1'b0;
  logic             out_ready_1 = 1'b0;
`ifdef DEMUX_COUNT_EN
  logic [15:0]      pop_cnt_0, pop_cnt_1;
`endif

  demux1_2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready),
    .data_out_0(data_out_0), .out_valid_0(out_valid_0), .out_ready_0(out_ready_0),
    .data_out_1(data_out_1), .out_valid_1(out_valid_1), .out_ready_1(out_ready_1)
`ifdef DEMUX_COUNT_EN
    , .pop_cnt_0(pop_cnt_0), .pop_cnt_1(pop_cnt_1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one queue per output; "untouched" means no push since reset, so the
  // head location still holds the cleared value 0.
  logic [WIDTH-1:0] q0[$], q1[$];
  bit               untouched0 = 1'b1, untouched1 = 1'b1;
  int               pc0 = 0, pc1 = 0;
  bit               started = 1'b0;
  bit               m_rdy, m_p0, m_p1;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      q0.delete(); q1.delete();
      untouched0 = 1'b1; untouched1 = 1'b1;
      pc0 = 0; pc1 = 0;
    end else begin
      m_rdy = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      m_p0  = (q0.size() > 0) && out_ready_0;
      m_p1  = (q1.size() > 0) && out_ready_1;
      if (m_p0) begin void'(q0.pop_front()); pc0 = (pc0 + 1) % 65536; end
      if (m_p1) begin void'(q1.pop_front()); pc1 = (pc1 + 1) % 65536; end
      if (in_valid && m_rdy) begin
        if (sel) begin q1.push_back(data_in); untouched1 = 1'b0; end
        else     begin q0.push_back(data_in); untouched0 = 1'b0; end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid0", 32'(out_valid_0), 32'(q0.size() > 0));
      chk("m_valid1", 32'(out_valid_1), 32'(q1.size() > 0));
      if (q0.size() > 0) chk("m_data0", 32'(data_out_0), 32'(q0[0]));
      else if (untouched0) chk("m_data0_clr", 32'(data_out_0), 32'h0);
      if (q1.size() > 0) chk("m_data1", 32'(data_out_1), 32'(q1[0]));
      else if (untouched1) chk("m_data1_clr", 32'(data_out_1), 32'h0);
      chk("m_in_ready", 32'(in_ready),
          32'(sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
`ifdef DEMUX_COUNT_EN
      chk("m_pop_cnt_0", 32'(pop_cnt_0), 32'(pc0));
      chk("m_pop_cnt_1", 32'(pop_cnt_1), 32'(pc1));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [WIDTH-1:0] d);
    sel = s; data_in = d; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  int budget;
  bit accepted;

  initial begin
    // Reset
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid0", 32'(out_valid_0), 32'h0);
    chk("rst_valid1", 32'(out_valid_1), 32'h0);
    chk("rst_data0", 32'(data_out_0), 32'h0);
    chk("rst_data1", 32'(data_out_1), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
`ifdef DEMUX_COUNT_EN
    chk("rst_pop_cnt_0", 32'(pop_cnt_0), 32'h0);
`endif

    // Basic routing
    out_ready_0 = 1'b1; out_ready_1 = 1'b1;
    send(1'b0, 4'h5);
    chk("route_data0", 32'(data_out_0), 32'h5);
    chk("route_valid0", 32'(out_valid_0), 32'h1);
    send(1'b1, 4'hA);
    chk("route_data1", 32'(data_out_1), 32'hA);
    chk("route_valid1", 32'(out_valid_1), 32'h1);
    chk("route_valid0_gone", 32'(out_valid_0), 32'h0);
    cyc();

    // Full and back-pressure
    out_ready_0 = 1'b0;
    send(1'b0, 4'h1);
    send(1'b0, 4'h2);
    sel = 1'b0; #1;
    chk("full_ready_sel0", 32'(in_ready), 32'h0);
    sel = 1'b1; #1;
    chk("full_ready_sel1", 32'(in_ready), 32'h1);
    chk("full_head", 32'(data_out_0), 32'h1);
    out_ready_0 = 1'b1;
    cyc();
    chk("drain_second", 32'(data_out_0), 32'h2);
    cyc();
    chk("drain_empty", 32'(out_valid_0), 32'h0);

    // Simultaneous push/pop on a one-word FIFO
    out_ready_0 = 1'b0;
    send(1'b0, 4'h7);
    out_ready_0 = 1'b1;
    send(1'b0, 4'h3);
    chk("pp_valid", 32'(out_valid_0), 32'h1);
    chk("pp_data", 32'(data_out_0), 32'h3);
    cyc();
    chk("pp_empty", 32'(out_valid_0), 32'h0);

    // Sweep with random sink stalls
    for (int s = 0; s < 2; s++) begin
      for (int d = 0; d < 16; d++) begin
        sel = s[0]; data_in = d[WIDTH-1:0]; in_valid = 1'b1;
        budget = 50;
        do begin
          out_ready_0 = 1'($urandom_range(0, 1));
          out_ready_1 = 1'($urandom_range(0, 1));
          #1;
          accepted = in_ready;
          cyc();
          budget--;
        end while (!accepted && budget > 0);
        in_valid = 1'b0;
        chk("sweep_accept", 32'(accepted), 32'h1);
      end
    end
    out_ready_0 = 1'b1; out_ready_1 = 1'b1;
    repeat (4) cyc();
    chk("sweep_drained0", 32'(out_valid_0), 32'h0);
    chk("sweep_drained1", 32'(out_valid_1), 32'h0);

    // Mid-operation reset
    out_ready_0 = 1'b0; out_ready_1 = 1'b0;
    send(1'b0, 4'hC); send(1'b0, 4'hD);
    send(1'b1, 4'hE); send(1'b1, 4'hF);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_valid0", 32'(out_valid_0), 32'h0);
    chk("mrst_valid1", 32'(out_valid_1), 32'h0);
    chk("mrst_data0", 32'(data_out_0), 32'h0);
    chk("mrst_in_ready", 32'(in_ready), 32'h1);
`ifdef DEMUX_COUNT_EN
    chk("mrst_pop_cnt_0", 32'(pop_cnt_0), 32'h0);
    chk("mrst_pop_cnt_1", 32'(pop_cnt_1), 32'h0);
`endif
    out_ready_0 = 1'b1; out_ready_1 = 1'b1;
    repeat (2) cyc();
    send(1'b1, 4'h9);
    chk("post_rst_data1", 32'(data_out_1), 32'h9);
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
